uart_tx: RTL



---
 rtl/uart_pkg.sv | 40 ++++
 rtl/sync_parallel_counter.sv | 22 ++
 rtl/uart_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX state enum, bit-count constants
// and the per-frame configuration payload latched at acceptance.
package uart_pkg;

    localparam int unsigned OversampleBits = 4;
    localparam int unsigned DataBits       = 8;
    localparam int unsigned BitCountBits   = 3;

    localparam logic [1:0] ParityNone0 = 2'd0;
    localparam logic [1:0] ParityNone1 = 2'd1;
    localparam logic [1:0] ParityEven  = 2'd2;
    localparam logic [1:0] ParityOdd   = 2'd3;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop1,
        TxStop2
    } tx_state_e;

    typedef struct packed {
        logic [DataBits-1:0] data;
        logic [1:0]          parity_type;
        logic                nstop;
    } tx_frame_cfg_t;

    function automatic logic has_parity(input logic [1:0] pt);
        return !((pt == ParityNone0) || (pt == ParityNone1));
    endfunction

    // Even parity makes the total count of ones even; odd makes it odd.
    function automatic logic parity_bit(input logic [DataBits-1:0] d, input logic [1:0] pt);
        if (pt == ParityOdd)  return ~^d;
        if (pt == ParityEven) return ^d;
        return 1'b1;
    endfunction

endpackage

// File: rtl/sync_parallel_counter.sv
// Synchronous up-counter with clear priority over enable; wraps at full scale.
module sync_parallel_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [Width-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, optional parity, 1/2 stop bits, 16 clocks per bit.
// Define UART_TX_HOLD_BUFFER_EN to add a one-entry holding register for gapless back-to-back frames.
module uart_tx
    import uart_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                tx_en,
    input  logic [1:0]          parity_type,
    input  logic                nstop,
    input  logic [DataBits-1:0] data_in,
    input  logic                data_valid,
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                txd
);

    tx_state_e                 state;
    tx_frame_cfg_t             cur;
    tx_frame_cfg_t             incoming;
    tx_frame_cfg_t             next_cfg;
    logic [BitCountBits-1:0]   bit_cnt;
    logic [OversampleBits-1:0] cyc;
    logic                      par_q;
    logic                      cyc_last;
    logic                      accept_c;
    logic                      final_c;
    logic                      start_c;

    assign incoming = '{data: data_in, parity_type: parity_type, nstop: nstop};
    assign accept_c = data_valid & tx_ready;
    assign cyc_last = (cyc == {OversampleBits{1'b1}});
    assign final_c  = cyc_last & ((state == TxStop2) | ((state == TxStop1) & ~cur.nstop));

`ifdef UART_TX_HOLD_BUFFER_EN
    logic          hold_full;
    tx_frame_cfg_t hold_q;

    assign tx_ready = tx_en & ~hold_full;
    assign start_c  = ((state == TxIdle) & accept_c) | (final_c & (hold_full | accept_c));
    assign next_cfg = hold_full ? hold_q : incoming;

    // Bytes arriving mid-frame wait here until the current stop bit ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_q    <= '0;
        end else if (final_c & hold_full) begin
            hold_full <= 1'b0;
        end else if (accept_c & ~start_c) begin
            hold_full <= 1'b1;
            hold_q    <= incoming;
        end
    end
`else
    assign tx_ready = tx_en & ~tx_busy;
    assign start_c  = (state == TxIdle) & accept_c;
    assign next_cfg = incoming;
`endif

    sync_parallel_counter #(
        .Width(OversampleBits)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .clear (start_c),
        .enable(tx_busy),
        .count (cyc)
    );

    // Frame sequencer; every state lasts one full bit time of the shared timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= TxIdle;
            cur     <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (start_c) begin
                state   <= TxStart;
                cur     <= next_cfg;
                par_q   <= parity_bit(next_cfg.data, next_cfg.parity_type);
                bit_cnt <= '0;
                txd     <= 1'b0;
                tx_busy <= 1'b1;
                tx_done <= final_c;
            end else if (cyc_last) begin
                case (state)
                    TxStart: begin
                        state <= TxData;
                        txd   <= cur.data[0];
                    end
                    TxData: begin
                        if (bit_cnt == BitCountBits'(DataBits - 1)) begin
                            if (has_parity(cur.parity_type)) begin
                                state <= TxParity;
                                txd   <= par_q;
                            end else begin
                                state <= TxStop1;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + BitCountBits'(1);
                            cur.data <= cur.data >> 1;
                            txd      <= cur.data[1];
                        end
                    end
                    TxParity: begin
                        state <= TxStop1;
                        txd   <= 1'b1;
                    end
                    TxStop1: begin
                        txd <= 1'b1;
                        if (cur.nstop) begin
                            state <= TxStop2;
                        end else begin
                            state   <= TxIdle;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end
                    end
                    TxStop2: begin
                        txd     <= 1'b1;
                        state   <= TxIdle;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                    default: begin
                        state <= TxIdle;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
